fan_ctrl_multi: RTL and testbench
=================================

Name: fan_ctrl_multi

Overview:
Multi-channel fan controller front-end, the next generation of the single-channel fan controller.
- Generates staggered, round-robin PID update strobes for CHANNELS fans from one clock-enable divider.
- Converts each channel's signed PID result into a PWM duty, with a minimum-duty clamp.
- Drives one PWM pin per channel, with duty updates only at period boundaries (glitch-free).
- Adds kick-start: every spin-up from 0 runs full-on for a fixed number of PWM periods.
- Sits between the time-multiplexed PID core and the fan pins.

Parameters:
CHANNELS, 4, number of fan channels (>=1)
ADC_BITWIDTH, 8, ADC/set-value width W; PID value is W+1 bits signed
PID_CLK_DIV, 39999, clk_en_i ticks per PID strobe minus 1
PWM_CLK_DIV, 1, clk_en_i ticks per PWM counter step minus 1
KICK_PERIODS, 16, full-on PWM periods on spin-up (0 disables kick)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
clk_en_i  in  1  global clock enable (1 MHz nominal)
enable_i  in  CHANNELS  per-channel run enable
pid_val_i  in  CHANNELS*(W+1)  packed signed PID outputs; channel c at bits [c*(W+1) +: W+1]
pwm_period_i  in  W+1  PWM period counter terminal value
pwm_min_i  in  W  minimum nonzero duty
pid_strobe_o  out  CHANNELS  one-hot, one-clk pulse: compute PID for this channel
pid_ch_o  out  clog2(CHANNELS) (min 1)  index of the channel currently strobed
pwm_o  out  CHANNELS  PWM pins
period_start_o  out  1  one-clk pulse at each PWM period wrap

Behaviour:
- Reset:
  - All counters, channel index, shadow duties and kick counters are 0.
  - pwm_o, pid_strobe_o, pid_ch_o and period_start_o are 0.
  - Reset mid-period aborts the current period and any kick immediately.
- PID scheduler:
  - div_cnt counts 0..PID_CLK_DIV on clk_en_i.
  - In the clk_en_i cycle with div_cnt==PID_CLK_DIV: div_cnt goes to 0 and the registered strobe for channel ch_idx is set.
  - pid_strobe_o is high for exactly one clk, on the cycle after that clk_en_i cycle. pid_ch_o holds the strobed index from that cycle until the next strobe.
  - ch_idx then increments and wraps CHANNELS-1 -> 0.
  - Each channel is strobed every (PID_CLK_DIV+1)*CHANNELS enables.
  - Disabled channels are still strobed.
- PWM timebase (shared by all channels):
  - Prescaler counts 0..PWM_CLK_DIV on clk_en_i; pwm_cnt steps on prescaler wrap.
  - pwm_cnt counts 0..per_q, where per_q is pwm_period_i latched at the wrap.
  - At the step where pwm_cnt==per_q: pwm_cnt goes to 0, period_start_o pulses for 1 clk, and every channel loads its shadow duty.
  - per_q==0: pwm_cnt stays 0 and every step is a wrap.
- Duty conversion (pure function, evaluated on pid_val_i):
  - v<0: raw = -v, saturated to 2^W-1 (so v=-2^W gives 2^W-1). v>=0: raw = 0.
  - raw!=0 and raw<pwm_min_i: duty = pwm_min_i; otherwise duty = raw.
- Channel output:
  - pwm_o[c] is registered: high iff enable_i[c] and (kick_cnt[c]!=0 or pwm_cnt < duty_q[c]).
  - duty_q > per_q gives a constant high output.
- Kick-start:
  - At a period wrap where duty_q goes 0 -> nonzero: kick_cnt = KICK_PERIODS.
  - kick_cnt decrements at each later wrap while it is nonzero.
  - A new duty of 0 at a wrap clears kick_cnt.
- Enable:
  - enable_i[c]=0 forces duty_q and kick_cnt to 0, and pwm_o[c] to 0 on the next clk.
  - Re-enabling loads duty at the next wrap, and a kick applies.
- Latency:
  - A duty change on pid_val_i mid-period takes effect at the next wrap.
  - Mid-period changes on pwm_period_i also take effect at the next wrap.
- clk_en_i low: all counters hold and pwm_o holds.

Decomposition:
- Package fan_ctrl_pkg holds:
  - the PID-width and channel-index-width constants;
  - the signed-PID-to-duty conversion function (saturation plus min clamp);
  - the clog2 function.
- Sub-module fan_pwm_channel, instantiated CHANNELS times. It owns one channel's duty_q, kick_cnt and output register. Its inputs are the shared pwm_cnt, the wrap pulse, enable and the converted duty.
- The scheduler and timebase stay in the top level.

Test Plan:
1. Reset: rst_i high 2 clk during activity -> next cycle pwm_o=0, pid_strobe_o=0, period_start_o=0; after release, first strobe is channel 0.
2. Scheduler, CHANNELS=4, PID_CLK_DIV=3, clk_en_i=1 -> pid_strobe_o = 0001, 0010, 0100, 1000, 0001 at 4-clk spacing; pid_ch_o = 0, 1, 2, 3, 0.
3. Duty, PWM_CLK_DIV=0, period=9, pid=-3, min=0, KICK_PERIODS=0 -> pwm_o[0] high 3 of every 10 clk; pid=+7 -> 0 high; pid=-256 -> constant high.
4. Min clamp: min=5, pid=-2 -> 5 of 10 high; pid=0 -> 0 high (no clamp at 0).
5. Kick: KICK_PERIODS=2, duty 0 -> 3 -> 2 full-high periods (20 clk) then 3/10; duty set to 0 during kick -> low from next wrap.
6. Mid-period change: pid -3 -> -7 at pwm_cnt=4 -> current period keeps 3-high and the next period is 7-high; enable_i[1] drop -> pwm_o[1]=0 next clk while other channels are unaffected.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared constants and helpers for the multi-channel fan controller:
// width helpers and the signed-PID to PWM-duty conversion.
package fan_ctrl_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index/counter width able to address n states, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // The PID core emits one extra (sign) bit over the ADC width.
    function automatic int pid_width(input int adc_bits);
        return adc_bits + 1;
    endfunction

    // Negative PID output means "cool harder": its magnitude is the duty,
    // saturated to 2^w-1, and any nonzero duty is lifted to min_duty.
    function automatic logic [31:0] pid_to_duty(input logic signed [31:0] v,
                                                input logic [31:0] min_duty,
                                                input int w);
        logic [31:0] sat;
        logic [31:0] mag;
        logic [31:0] raw;
        sat = (32'd1 << w) - 32'd1;
        mag = 32'(-v);
        raw = '0;
        if (v < 0) raw = (mag > sat) ? sat : mag;
        if (raw != '0 && raw < min_duty) return min_duty;
        return raw;
    endfunction

endpackage

// File: rtl/fan_pwm_channel.sv
// One fan channel: shadow duty, kick-start counter and registered PWM pin.
// Duty and kick state change only at period wraps, or clear when disabled.
module fan_pwm_channel
    import fan_ctrl_pkg::*;
#(
    parameter int W            = 8,
    parameter int KICK_PERIODS = 16,
    parameter int KW           = 5
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W:0]   cnt_next,
    input  logic         wrap,
    input  logic         enable,
    input  logic [W-1:0] duty,
    output logic         pwm
);

    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS);
    localparam logic [KW-1:0] KICK_ONE  = 1;

    logic [W-1:0]  duty_reg;
    logic [W-1:0]  duty_next;
    logic [KW-1:0] kick_reg;
    logic [KW-1:0] kick_next;
    logic          pwm_reg;

    always_comb begin
        duty_next = duty_reg;
        kick_next = kick_reg;
        if (!enable) begin
            duty_next = '0;
            kick_next = '0;
        end else if (wrap) begin
            duty_next = duty;
            if (duty == '0)
                kick_next = '0;
            else if (duty_reg == '0)
                kick_next = KICK_LOAD;
            else if (kick_reg != '0)
                kick_next = kick_reg - KICK_ONE;
        end
    end

    // The pin is evaluated from next-state values so it lines up with the
    // counter edge and stays put while the clock enable is low.
    always_ff @(posedge clk) begin
        if (srst) begin
            duty_reg <= '0;
            kick_reg <= '0;
            pwm_reg  <= 1'b0;
        end else begin
            duty_reg <= duty_next;
            kick_reg <= kick_next;
            pwm_reg  <= enable && ((kick_next != '0) || (cnt_next < {1'b0, duty_next}));
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/fan_ctrl_multi.sv
// Multi-channel fan controller front-end: round-robin PID strobe scheduler,
// shared PWM timebase and one fan_pwm_channel per fan.
module fan_ctrl_multi
    import fan_ctrl_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int ADC_BITWIDTH = 8,
    parameter int PID_CLK_DIV  = 39999,
    parameter int PWM_CLK_DIV  = 1,
    parameter int KICK_PERIODS = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clk_en_i,
    input  logic [CHANNELS-1:0]                        enable_i,
    input  logic [CHANNELS*pid_width(ADC_BITWIDTH)-1:0] pid_val_i,
    input  logic [ADC_BITWIDTH:0]                      pwm_period_i,
    input  logic [ADC_BITWIDTH-1:0]                    pwm_min_i,
    output logic [CHANNELS-1:0]                        pid_strobe_o,
    output logic [idx_width(CHANNELS)-1:0]             pid_ch_o,
    output logic [CHANNELS-1:0]                        pwm_o,
    output logic                                       period_start_o
);

    localparam int W   = ADC_BITWIDTH;
    localparam int PW  = pid_width(ADC_BITWIDTH);
    localparam int CW  = idx_width(CHANNELS);
    localparam int DW  = idx_width(PID_CLK_DIV + 1);
    localparam int PRW = idx_width(PWM_CLK_DIV + 1);
    localparam int KW  = idx_width(KICK_PERIODS + 1);

    localparam logic [DW-1:0]       DIV_LAST   = DW'(PID_CLK_DIV);
    localparam logic [DW-1:0]       DIV_ONE    = 1;
    localparam logic [CW-1:0]       CH_LAST    = CW'(CHANNELS - 1);
    localparam logic [CW-1:0]       CH_ONE     = 1;
    localparam logic [CHANNELS-1:0] STROBE_ONE = 1;
    localparam logic [PRW-1:0]      PRE_LAST   = PRW'(PWM_CLK_DIV);
    localparam logic [PRW-1:0]      PRE_ONE    = 1;
    localparam logic [W:0]          CNT_ONE    = 1;

    // PID scheduler
    logic [DW-1:0]       div_cnt_reg;
    logic [CW-1:0]       ch_idx_reg;
    logic [CW-1:0]       ch_out_reg;
    logic [CHANNELS-1:0] strobe_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_reg <= '0;
            ch_idx_reg  <= '0;
            ch_out_reg  <= '0;
            strobe_reg  <= '0;
        end else begin
            strobe_reg <= '0;
            if (clk_en_i) begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_reg <= '0;
                    strobe_reg  <= STROBE_ONE << ch_idx_reg;
                    ch_out_reg  <= ch_idx_reg;
                    ch_idx_reg  <= (ch_idx_reg == CH_LAST) ? '0 : ch_idx_reg + CH_ONE;
                end else begin
                    div_cnt_reg <= div_cnt_reg + DIV_ONE;
                end
            end
        end
    end

    assign pid_strobe_o = strobe_reg;
    assign pid_ch_o     = ch_out_reg;

    // Shared PWM timebase; the period register only follows pwm_period_i at wraps
    logic [PRW-1:0] pre_cnt_reg;
    logic [W:0]     pwm_cnt_reg;
    logic [W:0]     per_reg;
    logic [W:0]     cnt_next;
    logic           step;
    logic           wrap;
    logic           period_start_reg;

    always_comb begin
        step     = clk_en_i && (pre_cnt_reg == PRE_LAST);
        wrap     = step && (pwm_cnt_reg == per_reg);
        cnt_next = pwm_cnt_reg;
        if (wrap)
            cnt_next = '0;
        else if (step)
            cnt_next = pwm_cnt_reg + CNT_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_cnt_reg      <= '0;
            pwm_cnt_reg      <= '0;
            per_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= wrap;
            pwm_cnt_reg      <= cnt_next;
            if (clk_en_i)
                pre_cnt_reg <= step ? '0 : pre_cnt_reg + PRE_ONE;
            if (wrap)
                per_reg <= pwm_period_i;
        end
    end

    assign period_start_o = period_start_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic signed [PW-1:0] pid_c;
            logic [W-1:0]         duty_c;

            assign pid_c  = pid_val_i[gi*PW +: PW];
            assign duty_c = W'(pid_to_duty({{(32-PW){pid_c[PW-1]}}, pid_c},
                                           {{(32-W){1'b0}}, pwm_min_i}, W));

            fan_pwm_channel #(
                .W            (W),
                .KICK_PERIODS (KICK_PERIODS),
                .KW           (KW)
            ) u_ch (
                .clk      (clk_i),
                .srst     (rst_i),
                .cnt_next (cnt_next),
                .wrap     (wrap),
                .enable   (enable_i[gi]),
                .duty     (duty_c),
                .pwm      (pwm_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Self-checking bench for fan_ctrl_multi: 4 channels, PID divider 3,
// PWM divider 0, period 9 (10 clk), kick of 2 periods.
module tb_fan_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clk_en_i = 1'b1;
    logic [3:0]  enable_i = '0;
    logic [8:0]  pid [4];
    logic [35:0] pid_val_i;
    logic [8:0]  pwm_period_i = 9'd9;
    logic [7:0]  pwm_min_i = '0;
    logic [3:0]  pid_strobe_o;
    logic [1:0]  pid_ch_o;
    logic [3:0]  pwm_o;
    logic        period_start_o;

    assign pid_val_i = {pid[3], pid[2], pid[1], pid[0]};

    fan_ctrl_multi #(
        .CHANNELS     (4),
        .ADC_BITWIDTH (8),
        .PID_CLK_DIV  (3),
        .PWM_CLK_DIV  (0),
        .KICK_PERIODS (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clk_en_i       (clk_en_i),
        .enable_i       (enable_i),
        .pid_val_i      (pid_val_i),
        .pwm_period_i   (pwm_period_i),
        .pwm_min_i      (pwm_min_i),
        .pid_strobe_o   (pid_strobe_o),
        .pid_ch_o       (pid_ch_o),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [8:0] pid;
        logic [7:0] pmin;
        int         highs;
    } vec_t;

    typedef struct {
        int strobe;
        int ch;
        int cyc;
    } sched_t;

    vec_t   vecs[$];
    int     exp_q[$];
    sched_t sq[$];

    function automatic logic [8:0] neg(input int m);
        return 9'(-m);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called on a negedge; returns on the negedge of a period-start cycle.
    task automatic wait_ps();
        for (int k = 0; k < 60 && !period_start_o; k++) @(negedge clk);
        if (!period_start_o) check("period_start_timeout", 0, 1);
    endtask

    // Counts channel-0 high cycles over one 10-clk period; optionally drives
    // a new channel-0 PID value at cycle change_at of that period.
    task automatic count_period(input int change_at, input logic [8:0] new_pid, output int n);
        wait_ps();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (pwm_o[0]) n++;
            if (i == change_at) pid[0] = new_pid;
            @(negedge clk);
        end
    endtask

    task automatic settle();
        int d;
        repeat (3) count_period(-1, 9'd0, d);
    endtask

    initial begin
        int n;
        int last_ch;
        logic [3:0] held;

        pid[0] = neg(256);
        pid[1] = neg(256);
        pid[2] = neg(256);
        pid[3] = 9'd0;

        vecs.push_back('{name:"duty_m3",     pid:neg(3),   pmin:8'd0, highs:3});
        vecs.push_back('{name:"duty_pos7",   pid:9'd7,     pmin:8'd0, highs:0});
        vecs.push_back('{name:"duty_m256",   pid:neg(256), pmin:8'd0, highs:10});
        vecs.push_back('{name:"clamp_m2",    pid:neg(2),   pmin:8'd5, highs:5});
        vecs.push_back('{name:"clamp_zero",  pid:9'd0,     pmin:8'd5, highs:0});
        vecs.push_back('{name:"duty_m9",     pid:neg(9),   pmin:8'd0, highs:9});
        vecs.push_back('{name:"clamp_above", pid:neg(6),   pmin:8'd5, highs:6});
        vecs.push_back('{name:"duty_over",   pid:neg(10),  pmin:8'd0, highs:10});

        // Reset in the middle of activity
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        enable_i = 4'b1111;
        repeat (40) @(negedge clk);
        check("pre_reset_pwm0", int'(pwm_o[0]), 1);
        rst_i = 1'b1;
        @(negedge clk);
        check("reset_pwm", int'(pwm_o), 0);
        check("reset_strobe", int'(pid_strobe_o), 0);
        check("reset_period_start", int'(period_start_o), 0);
        check("reset_ch", int'(pid_ch_o), 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Scheduler: one strobe every 4 clk, round robin from channel 0
        for (int i = 0; i < 5; i++)
            sq.push_back('{strobe:(1 << (i % 4)), ch:(i % 4), cyc:4 * (i + 1)});
        last_ch = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (pid_strobe_o != 4'd0) begin
                if (sq.size() == 0) begin
                    check("sched_extra_strobe", int'(pid_strobe_o), 0);
                end else begin
                    sched_t e;
                    e = sq.pop_front();
                    check("sched_strobe", int'(pid_strobe_o), e.strobe);
                    check("sched_ch", int'(pid_ch_o), e.ch);
                    check("sched_cycle", k, e.cyc);
                    last_ch = e.ch;
                end
            end else if (int'(pid_ch_o) != last_ch) begin
                check("sched_ch_hold", int'(pid_ch_o), last_ch);
            end
        end
        check("sched_all_seen", sq.size(), 0);

        // Table of duty / clamp vectors on channel 0
        foreach (vecs[i]) begin
            pid[0] = vecs[i].pid;
            pwm_min_i = vecs[i].pmin;
            exp_q.push_back(vecs[i].highs);
            settle();
            count_period(-1, 9'd0, n);
            check(vecs[i].name, n, exp_q.pop_front());
        end
        pwm_min_i = '0;

        // Mid-period duty change: current period keeps the old duty
        pid[0] = neg(3);
        settle();
        exp_q.push_back(3);
        exp_q.push_back(7);
        count_period(4, neg(7), n);
        check("mid_change_cur", n, exp_q.pop_front());
        count_period(-1, 9'd0, n);
        check("mid_change_next", n, exp_q.pop_front());

        // Enable drop on channel 1 only
        check("en_pre_pwm1", int'(pwm_o[1]), 1);
        enable_i[1] = 1'b0;
        @(negedge clk);
        check("en_drop_pwm1", int'(pwm_o[1]), 0);
        check("en_drop_pwm2", int'(pwm_o[2]), 1);
        enable_i[1] = 1'b1;
        @(negedge clk);
        check("en_back_before_wrap", int'(pwm_o[1]), 0);
        wait_ps();
        check("en_back_after_wrap", int'(pwm_o[1]), 1);

        // Clock enable low: everything holds
        @(negedge clk);
        held = pwm_o;
        clk_en_i = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (pwm_o !== held || period_start_o || pid_strobe_o != 4'd0)
                check("clk_en_hold", int'(pwm_o), int'(held));
        end
        check("clk_en_hold_end", int'(pwm_o), int'(held));
        clk_en_i = 1'b1;

        // Kick-start: 0 -> 3 gives two full periods then 3/10
        pid[0] = 9'd0;
        settle();
        exp_q.push_back(0);
        exp_q.push_back(10);
        exp_q.push_back(10);
        exp_q.push_back(3);
        count_period(0, neg(3), n);
        check("kick_before", n, exp_q.pop_front());
        count_period(-1, 9'd0, n);
        check("kick_p1", n, exp_q.pop_front());
        count_period(-1, 9'd0, n);
        check("kick_p2", n, exp_q.pop_front());
        count_period(-1, 9'd0, n);
        check("kick_done", n, exp_q.pop_front());

        // Kick aborted by a zero duty
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(10);
        exp_q.push_back(0);
        count_period(0, 9'd0, n);
        check("abort_setup", n, exp_q.pop_front());
        count_period(0, neg(3), n);
        check("abort_idle", n, exp_q.pop_front());
        count_period(3, 9'd0, n);
        check("abort_kick", n, exp_q.pop_front());
        count_period(-1, 9'd0, n);
        check("abort_after", n, exp_q.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
